qlm_pipe: RTL and testbench

//  Pipelined, parametrised quantised logarithmic (Mitchell-style) multiplier.

---
 rtl/qlm_pipe.sv | 139 +++++++++++++
 tb/tb_qlm_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qlm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : qlm_pipe
// Brief    : 3-stage valid/ready Mitchell-style quantised log multiplier.
// Revision : 1.0
// ============================================================================
module qlm_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 5,
    parameter int Q      = 7,
    parameter int SIGNED = 1,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int KW = $clog2(WIDTH);
    localparam int LW = KW + 1 + FRAC;
    localparam int PW = 2 * WIDTH + FRAC;

    function automatic logic [WIDTH-1:0] f_absq(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] m;
        m = (SIGNED != 0) ? (a ^ {WIDTH{a[WIDTH-1]}}) : a;
        m[Q-1:0] = '0;
        return m;
    endfunction

    function automatic logic [KW-1:0] f_lod(input logic [WIDTH-1:0] m);
        logic [KW-1:0] k;
        k = KW'(Q);
        for (int i = Q; i < WIDTH; i++) begin
            if (m[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Normalise the leading one to the MSB; the FRAC bits under it are the mantissa.
    function automatic logic [FRAC-1:0] f_mant(input logic [WIDTH-1:0] m, input logic [KW-1:0] k);
        logic [WIDTH-1:0] n;
        n = m << (KW'(WIDTH - 1) - k);
        return FRAC'(n >> (WIDTH - 1 - FRAC));
    endfunction

    // Handshake
    logic w_en1, w_en2, w_en3;
    logic r_v1, r_v2, r_v3;

    assign w_en3     = ~r_v3 | out_ready;
    assign w_en2     = ~r_v2 | w_en3;
    assign w_en1     = ~r_v1 | w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r_v3;

    // Stage 1 combinational: abs, quantise, leading-one, mantissa
    logic [WIDTH-1:0] w_ax, w_ay;
    logic [KW-1:0]    w_kx, w_ky;
    logic [FRAC-1:0]  w_fx, w_fy;
    logic             w_zx, w_zy, w_sx, w_sy;

    assign w_ax = f_absq(in_x);
    assign w_ay = f_absq(in_y);
    assign w_kx = f_lod(w_ax);
    assign w_ky = f_lod(w_ay);
    assign w_fx = f_mant(w_ax, w_kx);
    assign w_fy = f_mant(w_ay, w_ky);
    assign w_zx = (w_ax == '0);
    assign w_zy = (w_ay == '0);
    assign w_sx = (SIGNED != 0) && in_x[WIDTH-1];
    assign w_sy = (SIGNED != 0) && in_y[WIDTH-1];

    logic [KW-1:0]    r_s1_kx, r_s1_ky;
    logic [FRAC-1:0]  r_s1_fx, r_s1_fy;
    logic             r_s1_zero, r_s1_sign;
    logic [TAG_W-1:0] r_s1_tag;

    logic [LW-1:0]    r_s2_log;
    logic             r_s2_zero, r_s2_sign;
    logic [TAG_W-1:0] r_s2_tag;

    // Stage 3 combinational: antilog of the summed log
    logic [PW-1:0]      w_shift;
    logic [2*WIDTH-1:0] w_pabs;
    logic [2*WIDTH-1:0] w_p;

    assign w_shift = PW'({1'b1, r_s2_log[FRAC-1:0]}) << r_s2_log[LW-1:FRAC];
    assign w_pabs  = (2*WIDTH)'(w_shift >> FRAC);
    assign w_p     = r_s2_zero ? '0 : (w_pabs ^ {(2*WIDTH){r_s2_sign}});

    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            r_s1_kx   <= w_kx;
            r_s1_ky   <= w_ky;
            r_s1_fx   <= w_fx;
            r_s1_fy   <= w_fy;
            r_s1_zero <= w_zx | w_zy;
            r_s1_sign <= w_sx ^ w_sy;
            r_s1_tag  <= in_tag;
        end
        if (w_en2 && r_v1) begin
            // Mantissa overflow carries straight into the characteristic.
            r_s2_log  <= {1'b0, r_s1_kx, r_s1_fx} + {1'b0, r_s1_ky, r_s1_fy};
            r_s2_zero <= r_s1_zero;
            r_s2_sign <= r_s1_sign;
            r_s2_tag  <= r_s1_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            out_p   <= '0;
            out_tag <= '0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    out_p   <= w_p;
                    out_tag <= r_s2_tag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qlm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_qlm_pipe
// Brief    : Vector table plus scoreboard bench for qlm_pipe (16/5/7 signed).
// Revision : 1.0
// ============================================================================
module tb_qlm_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic [3:0]  out_tag;

    qlm_pipe #(.WIDTH(16), .FRAC(5), .Q(7), .SIGNED(1), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] p;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
    } vec_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    endtask

    // Independent integer reference for the approximate product.
    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] tx, ty;
        int ax, ay, kx, ky, fx, fy, s, ks, fs;
        longint pl;
        logic [31:0] r;
        tx = x[15] ? ~x : x;
        ty = y[15] ? ~y : y;
        ax = int'(tx) & ~127;
        ay = int'(ty) & ~127;
        if (ax == 0 || ay == 0) return 32'h0;
        kx = 0;
        while ((ax >> (kx + 1)) != 0) kx++;
        ky = 0;
        while ((ay >> (ky + 1)) != 0) ky++;
        fx = ((ax << 5) >> kx) - 32;
        fy = ((ay << 5) >> ky) - 32;
        s  = kx * 32 + fx + ky * 32 + fy;
        ks = s / 32;
        fs = s % 32;
        pl = (longint'(32 + fs) << ks) >> 5;
        r  = pl[31:0];
        return (x[15] ^ y[15]) ? ~r : r;
    endfunction

    // Output monitor: a drain happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got p=0x%08h tag=%0d expected no output", out_p, out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", out_p, e.p);
                check("tag", {28'h0, out_tag}, {28'h0, e.tag});
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag,
                        input logic [31:0] p);
        exp_t e;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_tag = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag = tag;
                e.p = p;
                q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_total++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        n_total++;
        $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    endtask

    task automatic latency_test(input string name);
        int n;
        in_valid = 1'b1;
        in_x = 16'd1024;
        in_y = 16'd512;
        in_tag = 4'd9;
        @(negedge clk);
        check({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        begin
            exp_t e;
            e.tag = 4'd9;
            e.p = 32'd524288;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, 32'd3);
        wait_empty();
    endtask

    vec_t vecs[10];
    logic [15:0] sx[8];
    logic [15:0] sy[8];
    logic [31:0] held_p;
    logic [3:0]  held_t;

    initial begin
        vecs[0] = '{16'd1024,  16'd512,   32'd524288};
        vecs[1] = '{16'd384,   16'd384,   32'd131072};
        vecs[2] = '{16'd100,   16'hEC78,  32'h0};        // y = -5000
        vecs[3] = '{16'hFC00,  16'd512,   32'hFFF8FFFF};
        vecs[4] = '{16'd0,     16'd1234,  32'h0};
        vecs[5] = '{16'hFFFF,  16'd4096,  32'h0};
        vecs[6] = '{16'd32767, 16'd32767, 32'h3E000000};
        vecs[7] = '{16'h8000,  16'd128,   32'hFFC0FFFF};
        vecs[8] = '{16'd128,   16'd128,   32'd16384};
        vecs[9] = '{16'hFF38,  16'hFED4,  32'd32768};    // -200 * -300

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_p", out_p, 32'h0);
        check("rst_out_tag", {28'h0, out_tag}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        latency_test("first");

        // Vector table, back to back
        for (int i = 0; i < 10; i++) send(vecs[i].x, vecs[i].y, 4'(i), vecs[i].p);
        in_valid = 1'b0;
        wait_empty();

        // Stream 8 pairs with a 5-cycle output stall mid-stream
        for (int i = 0; i < 8; i++) begin
            sx[i] = 16'($urandom_range(0, 65535));
            sy[i] = 16'($urandom_range(0, 65535));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send(sx[i], sy[i], 4'(i + 3), model(sx[i], sy[i]));
                in_valid = 1'b0;
            end
            begin
                repeat (1) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                check("stall_in_ready", {31'h0, in_ready}, 32'h0);
                check("stall_held", q.size(), 32'd3);
                check("stall_out_valid", {31'h0, out_valid}, 32'h1);
                held_p = out_p;
                held_t = out_tag;
                @(posedge clk);
                #1;
                check("hold_p", out_p, held_p);
                check("hold_tag", {28'h0, out_tag}, {28'h0, held_t});
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Reset with 3 pairs in flight
        send(16'd1024, 16'd1024, 4'd1, 32'd1048576);
        send(16'd2048, 16'd512, 4'd2, 32'd1048576);
        send(16'hFC00, 16'hFC00, 4'd3, model(16'hFC00, 16'hFC00));
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_p", out_p, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale_output", {31'h0, out_valid}, 32'h0);
        latency_test("post_rst");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
